multi_channel_interval_timer: RTL and testbench
===============================================

Name: multi_channel_interval_timer

Overview:
- NUM_CH independent interval counters, each WIDTH bits, sharing one clock.
- Per channel: 8-bit state command (RESET/RUN/HALT) and a mode select.
  - Saturating mode (mode=0): count up to the interval and hold.
  - Auto-reload mode (mode=1): periodic tick generation.
- Adds a per-channel completion tick, sticky pending flags with write-1-to-clear, and one maskable interrupt line for the control/peripheral layer.

Parameters:
- WIDTH, 32, counter and interval width per channel (>=2).
- NUM_CH, 4, number of independent channels (1..16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- state  in  8*NUM_CH  per-channel command; channel i at [8*i+7:8*i].
- interval  in  WIDTH*NUM_CH  per-channel terminal value; channel i at [WIDTH*i+WIDTH-1:WIDTH*i].
- mode  in  NUM_CH  per-channel: 0 = saturate, 1 = auto-reload.
- irq_en  in  NUM_CH  per-channel interrupt enable mask.
- irq_clear  in  NUM_CH  per-channel single-cycle clear of the pending flag.
- counter  out  WIDTH*NUM_CH  per-channel count value, registered.
- done  out  NUM_CH  level; channel i counter >= its interval (combinational from registered counter).
- tick  out  NUM_CH  registered one-cycle pulse when channel i counter reaches its interval.
- pending  out  NUM_CH  sticky tick flags.
- irq  out  1  OR of (pending & irq_en), combinational.

Behaviour:
- Reset (resetn=0, async): all counter=0, tick=0, pending=0. Held until resetn deasserts; first update on the following rising edge.
- State codes: 8'd0 RESET, 8'd1 RUN, 8'd2 HALT. Any other code behaves exactly as RESET.
- Per-channel sequential update, each rising edge:
  - RESET: counter<=0, tick<=0.
  - HALT: counter holds, tick<=0.
  - RUN, counter < interval: counter<=counter+1. tick<=1 iff counter+1 == interval, else 0.
  - RUN, counter >= interval, mode=0: counter holds, tick<=0.
  - RUN, counter >= interval, mode=1: counter<=0, tick<=0.
- Auto-reload sequence: 0,1,...,interval,0,...
  - Period is interval+1 cycles.
  - tick is high in the same cycle counter first shows interval.
- interval=0: counter stays 0 in both modes, tick never fires, done=1.
- interval lowered below counter mid-RUN:
  - mode=0: counter holds, no tick.
  - mode=1: counter reloads to 0 on the next RUN edge.
- interval changed while counting below it: takes effect on the next edge; no latching.
- Mode change mid-RUN: takes effect on the next edge.
- No arithmetic overflow: the increment is only taken when counter < interval. Counter never exceeds max(interval, value held when interval shrank).
- pending[i] per edge:
  - tick[i]=1 sets it (set wins over simultaneous irq_clear[i]=1).
  - else irq_clear[i]=1 clears it.
  - else holds.
  - The RESET state command does NOT clear pending; only resetn or irq_clear does.
- irq updates combinationally from pending/irq_en; masked channels still set pending.
- Channels fully independent; no shared arbitration.

Decomposition:
- Shared package/header: state code constants (STATE_RESET=8'd0, STATE_RUN=8'd1, STATE_HALT=8'd2) and mode constants (MODE_SATURATE=1'b0, MODE_RELOAD=1'b1).
- One sub-module, interval_timer_channel (parameter WIDTH), holds counter, tick, pending and done for one channel.
- Top level generates NUM_CH instances, slices the packed buses and builds irq.

Test Plan:
- Async reset mid-count: ch0 RUN, interval=10, mode=0, assert resetn=0 at count 5 between edges -> counter=0, tick=0, pending=0 immediately.
- Saturate: ch0 RUN, interval=5, mode=0 from 0 -> counter 1..5 on successive edges, tick high only in the cycle counter=5, then holds 5, done=1.
- Auto-reload: ch1 RUN, interval=3, mode=1 for 12 cycles -> counter 1,2,3,0,1,2,3,0,... and tick every 4th cycle, coincident with counter=3.
- HALT/resume and illegal code: ch2 RUN to 4, HALT 3 cycles -> counter stays 4, no tick. RUN resumes at 5. Then state=8'd7 -> counter=0.
- Interval edge cases: interval=0 in both modes -> counter 0, done=1, no tick. ch0 at 8, interval changed to 3 -> mode=0 holds 8; mode=1 reloads to 0 next edge.
- Interrupt path: irq_en=4'b0010, ticks on ch0 and ch1 -> pending=4'b0011, irq=1. irq_clear[1] in the same cycle as a new ch1 tick -> pending[1] stays 1. Clear alone -> irq=0 while pending[0] remains 1.

Source files
------------

// File: rtl/multi_channel_interval_timer_pkg.sv
// Shared command and mode encodings for the multi-channel interval timer.
package multi_channel_interval_timer_pkg;

  localparam int unsigned STATE_W = 8;

  localparam logic [STATE_W-1:0] STATE_RESET = 8'd0;
  localparam logic [STATE_W-1:0] STATE_RUN   = 8'd1;
  localparam logic [STATE_W-1:0] STATE_HALT  = 8'd2;

  localparam logic MODE_SATURATE = 1'b0;
  localparam logic MODE_RELOAD   = 1'b1;

endpackage

// File: rtl/interval_timer_channel.sv
// One interval counter: saturating or auto-reload count, completion tick,
// sticky pending flag with write-1-to-clear.
module interval_timer_channel
  import multi_channel_interval_timer_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [STATE_W-1:0] state,
  input  logic [WIDTH-1:0]   interval,
  input  logic               mode,
  input  logic               irq_clear,
  output logic [WIDTH-1:0]   counter,
  output logic               tick,
  output logic               pending,
  output logic               done
);

  logic [WIDTH-1:0] cnt_nxt;
  logic             tick_nxt;
  logic             pend_nxt;

  // Next-state: increment only below the interval, so the counter can never wrap.
  always_comb begin
    cnt_nxt  = counter;
    tick_nxt = 1'b0;
    pend_nxt = tick | (pending & ~irq_clear);
    case (state)
      STATE_RUN: begin
        if (counter < interval) begin
          cnt_nxt  = counter + WIDTH'(1);
          tick_nxt = (cnt_nxt == interval);
        end else begin
          case (mode)
            MODE_SATURATE: cnt_nxt = counter;
            MODE_RELOAD:   cnt_nxt = '0;
          endcase
        end
      end
      STATE_HALT:  cnt_nxt = counter;
      STATE_RESET: cnt_nxt = '0;
      default:     cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      counter <= '0;
      tick    <= 1'b0;
      pending <= 1'b0;
    end else begin
      counter <= cnt_nxt;
      tick    <= tick_nxt;
      pending <= pend_nxt;
    end
  end

  assign done = (counter >= interval);

endmodule

// File: rtl/multi_channel_interval_timer.sv
// NUM_CH independent interval timers with a shared maskable interrupt line.
module multi_channel_interval_timer
  import multi_channel_interval_timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [STATE_W*NUM_CH-1:0] state,
  input  logic [WIDTH*NUM_CH-1:0]   interval,
  input  logic [NUM_CH-1:0]         mode,
  input  logic [NUM_CH-1:0]         irq_en,
  input  logic [NUM_CH-1:0]         irq_clear,
  output logic [WIDTH*NUM_CH-1:0]   counter,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         tick,
  output logic [NUM_CH-1:0]         pending,
  output logic                      irq
);

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    interval_timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .state     (state[STATE_W*i +: STATE_W]),
      .interval  (interval[WIDTH*i +: WIDTH]),
      .mode      (mode[i]),
      .irq_clear (irq_clear[i]),
      .counter   (counter[WIDTH*i +: WIDTH]),
      .tick      (tick[i]),
      .pending   (pending[i]),
      .done      (done[i])
    );
  end

  assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_multi_channel_interval_timer.sv
// Directed bench for multi_channel_interval_timer with a queue-based scoreboard.
module tb_multi_channel_interval_timer;

  localparam int W = 8;
  localparam int N = 4;
  localparam logic [7:0] RST  = 8'd0;
  localparam logic [7:0] RUN  = 8'd1;
  localparam logic [7:0] HALT = 8'd2;

  logic           clk = 1'b0;
  logic           resetn;
  logic [8*N-1:0] state;
  logic [W*N-1:0] interval;
  logic [N-1:0]   mode, irq_en, irq_clear;
  logic [W*N-1:0] counter;
  logic [N-1:0]   done, tick, pending;
  logic           irq;

  multi_channel_interval_timer #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .state     (state),
    .interval  (interval),
    .mode      (mode),
    .irq_en    (irq_en),
    .irq_clear (irq_clear),
    .counter   (counter),
    .done      (done),
    .tick      (tick),
    .pending   (pending),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    string        tag;
    int           ch;
    logic [W-1:0] cnt;
    logic         tk;
    logic         dn;
    bit           chk;
    logic [N-1:0] pd;
    logic         ir;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input string tag, input int ch, input int cnt, input bit tk,
                          input bit dn, input bit chk = 1'b0, input logic [N-1:0] pd = '0,
                          input bit ir = 1'b0, input int dly = 1);
    exp_t e;
    e.cyc = cyc + dly;
    e.tag = tag;
    e.ch  = ch;
    e.cnt = W'(cnt);
    e.tk  = tk;
    e.dn  = dn;
    e.chk = chk;
    e.pd  = pd;
    e.ir  = ir;
    q.push_back(e);
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [7:0] st, input logic [W-1:0] iv,
                        input logic md);
    state[ch*8 +: 8]    = st;
    interval[ch*W +: W] = iv;
    mode[ch]            = md;
  endtask

  task automatic cleanup();
    state     = '0;
    mode      = '0;
    irq_en    = '0;
    irq_clear = '1;
    nxt();
    nxt();
    irq_clear = '0;
  endtask

  // Monitor: compare every due expectation on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t         e;
        logic [W-1:0] gc;
        e  = q.pop_front();
        gc = counter[e.ch*W +: W];
        total++;
        if (gc !== e.cnt || tick[e.ch] !== e.tk || done[e.ch] !== e.dn ||
            (e.chk && (pending !== e.pd || irq !== e.ir))) begin
          bad++;
          $display("FAIL %s ch%0d @cyc%0d: got cnt=%0d tick=%b done=%b pend=%b irq=%b, need cnt=%0d tick=%b done=%b pend=%b irq=%b (pend/irq checked=%0d)",
                   e.tag, e.ch, e.cyc, gc, tick[e.ch], done[e.ch], pending, irq,
                   e.cnt, e.tk, e.dn, e.pd, e.ir, e.chk);
        end
      end
    end
  end

  initial begin
    int w;
    resetn    = 1'b0;
    state     = '0;
    interval  = '0;
    mode      = '0;
    irq_en    = '0;
    irq_clear = '0;
    nxt();
    push_exp("reset", 0, 0, 0, 1, 1, 4'b0000, 0);
    nxt();
    resetn = 1'b1;

    // Saturating count to 5, then RESET command must keep pending, W1C clears it
    set_ch(0, RUN, 8'd5, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      push_exp("saturate", 0, (k < 5) ? k : 5, k == 5, k >= 5, k >= 6,
               (k >= 6) ? 4'b0001 : 4'b0000, 0);
      nxt();
    end
    set_ch(0, RST, 8'd5, 1'b0);
    push_exp("rstcmd_keeps_pend", 0, 0, 0, 0, 1, 4'b0001, 0);
    nxt();
    irq_clear = 4'b0001;
    push_exp("w1c", 0, 0, 0, 0, 1, 4'b0000, 0);
    nxt();
    irq_clear = '0;

    // Asynchronous reset between edges while counting
    set_ch(0, RUN, 8'd10, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      push_exp("count_to_5", 0, k, 0, 0);
      nxt();
    end
    @(posedge clk);
    #2;
    resetn = 1'b0;
    push_exp("async_reset", 0, 0, 0, 0, 1, 4'b0000, 0, 0);
    nxt();
    set_ch(0, RST, 8'd10, 1'b0);
    resetn = 1'b1;

    // Auto-reload, interval 3: period 4, tick with counter=3
    set_ch(1, RUN, 8'd3, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      push_exp("reload", 1, k % 4, (k % 4) == 3, (k % 4) == 3);
      nxt();
    end
    cleanup();

    // HALT holds, RUN resumes, illegal code acts as RESET
    set_ch(2, RUN, 8'd20, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      push_exp("run_ch2", 2, k, 0, 0);
      nxt();
    end
    set_ch(2, HALT, 8'd20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push_exp("halt", 2, 4, 0, 0);
      nxt();
    end
    set_ch(2, RUN, 8'd20, 1'b0);
    push_exp("resume", 2, 5, 0, 0);
    nxt();
    set_ch(2, 8'd7, 8'd20, 1'b0);
    push_exp("illegal_code", 2, 0, 0, 0);
    nxt();
    cleanup();

    // interval = 0 in both modes
    set_ch(3, RUN, 8'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push_exp("ival0_sat", 3, 0, 0, 1, 1, 4'b0000, 0);
      nxt();
    end
    set_ch(3, RUN, 8'd0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      push_exp("ival0_rel", 3, 0, 0, 1, 1, 4'b0000, 0);
      nxt();
    end

    // Interval lowered below the count: saturate holds, reload restarts
    set_ch(0, RUN, 8'd20, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      push_exp("run_to_8", 0, k, 0, 0);
      nxt();
    end
    set_ch(0, RUN, 8'd3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push_exp("shrink_sat", 0, 8, 0, 1);
      nxt();
    end
    set_ch(0, RUN, 8'd3, 1'b1);
    push_exp("shrink_rel", 0, 0, 0, 0);
    nxt();
    push_exp("shrink_rel_next", 0, 1, 0, 0);
    nxt();
    cleanup();

    // Interrupt path: mask, set-wins-over-clear, clear alone
    irq_en = 4'b0010;
    set_ch(0, RUN, 8'd2, 1'b0);
    set_ch(1, RUN, 8'd2, 1'b1);
    push_exp("irq_e1", 1, 1, 0, 0, 1, 4'b0000, 0);
    nxt();
    push_exp("irq_e2", 1, 2, 1, 1, 1, 4'b0000, 0);
    push_exp("irq_e2_ch0", 0, 2, 1, 1);
    nxt();
    push_exp("irq_e3", 1, 0, 0, 0, 1, 4'b0011, 1);
    nxt();
    push_exp("irq_e4", 1, 1, 0, 0, 1, 4'b0011, 1);
    nxt();
    push_exp("irq_e5", 1, 2, 1, 1, 1, 4'b0011, 1);
    nxt();
    irq_clear = 4'b0010;
    push_exp("set_wins", 1, 0, 0, 0, 1, 4'b0011, 1);
    nxt();
    set_ch(1, HALT, 8'd2, 1'b1);
    push_exp("clear_alone", 1, 0, 0, 0, 1, 4'b0001, 0);
    nxt();
    irq_clear = '0;
    irq_en    = 4'b0011;
    push_exp("unmask_ch0", 0, 2, 0, 1, 1, 4'b0001, 1);
    nxt();

    w = 0;
    while (q.size() > 0 && w < 10) begin
      nxt();
      w++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expectations, need 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
